// File: rtl/iter_shifter.sv
// ============================================================================
// iter_shifter : iterative one-bit-per-cycle RV32I shift unit (SLL/SRL/SRA)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module iter_shifter #(
  parameter int XLEN = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [1:0]              op_i,
  input  logic [XLEN-1:0]         in_i,
  input  logic [$clog2(XLEN)-1:0] shamt_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [XLEN-1:0]         out_o
);

  localparam int SW = $clog2(XLEN);

  localparam logic [1:0]    C_OP_SLL  = 2'b00;
  localparam logic [1:0]    C_OP_SRA  = 2'b11;
  localparam logic [SW-1:0] C_CNT_ONE = {{(SW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   data_q;
  logic [XLEN-1:0]   data_d;
  logic [SW-1:0]     cnt_q;
  logic [1:0]        kind_q;
  logic [XLEN-1:0]   out_q;
  logic              done_q;

  // Reserved encoding 2'b10 falls through to the logical right shift.
  always_comb begin
    data_d = {1'b0, data_q[XLEN-1:1]};
    case (kind_q)
      C_OP_SLL: data_d = {data_q[XLEN-2:0], 1'b0};
      C_OP_SRA: data_d = {data_q[XLEN-1], data_q[XLEN-1:1]};
      default:  data_d = {1'b0, data_q[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      kind_q  <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            data_q  <= in_i;
            cnt_q   <= shamt_i;
            kind_q  <= op_i;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt_q == '0) begin
            out_q   <= data_q;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            data_q <= data_d;
            cnt_q  <= cnt_q - C_CNT_ONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == ST_SHIFT);
  assign done_o = done_q;
  assign out_o  = out_q;

endmodule

`default_nettype wire
